riscv_imm_gen_pipe: RTL and testbench

Pipelined, parametrised RISC-V immediate generator for the decode stage of the pipelined core. It decodes every base-ISA immediate format (I, shift-I, S, B, U, J) and sign-extends the result to XLEN. It registers the result behind a valid/ready handshake with a two-entry skid buffer, so decode back-pressure never creates a combinational path back to fetch. A format tag and an unsupported-opcode flag go downstream for the control unit.

---
 rtl/riscv_imm_gen_pipe_pkg.sv | 31 +++
 rtl/riscv_imm_gen_pipe_if.sv | 27 ++
 rtl/riscv_imm_gen_pipe_decode.sv | 75 +++++++
 rtl/riscv_imm_gen_pipe.sv | 104 ++++++++++
 tb/tb_riscv_imm_gen_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_imm_gen_pipe_pkg.sv
// Shared opcode constants and the immediate-format tag used by the
// decode-stage immediate generator and its downstream control logic.
package riscv_imm_pkg;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] LOAD      = 7'h03;
  localparam logic [6:0] JALR      = 7'h67;
  localparam logic [6:0] SYSTEM    = 7'h73;
  localparam logic [6:0] OP_IMM_32 = 7'h1B;
  localparam logic [6:0] STORE     = 7'h23;
  localparam logic [6:0] BRANCH    = 7'h63;
  localparam logic [6:0] LUI       = 7'h37;
  localparam logic [6:0] AUIPC     = 7'h17;
  localparam logic [6:0] JAL       = 7'h6F;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } imm_fmt_t;

  // SLLI/SRLI/SRAI carry a shift amount rather than a signed immediate.
  function automatic logic isShiftImm(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/riscv_imm_gen_pipe_if.sv
// Instruction-in / immediate-out stream bundle. The slave modport is the
// generator's view; the master modport is the fetch/control side.
interface riscv_imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  import riscv_imm_pkg::*;

  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     Instruction_bus_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] Immediate_o;
  imm_fmt_t        imm_fmt_o;
  logic            unsupported_o;

  modport slave (
    input  in_valid_i, Instruction_bus_i, out_ready_i,
    output in_ready_o, out_valid_o, Immediate_o, imm_fmt_o, unsupported_o
  );

  modport master (
    output in_valid_i, Instruction_bus_i, out_ready_i,
    input  in_ready_o, out_valid_o, Immediate_o, imm_fmt_o, unsupported_o
  );

endinterface

// File: rtl/riscv_imm_gen_pipe_decode.sv
// Purely combinational immediate decoder: every format is first assembled
// as a 32-bit value whose bit 31 is the sign, then widened to XLEN.
module imm_decode
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_t        fmt_o,
  output logic            unsupported_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] raw;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  always_comb begin
    raw           = '0;
    fmt_o         = FMT_NONE;
    unsupported_o = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (isShiftImm(funct3)) begin
          // Bit 30 selects arithmetic vs logical shift and is never part of shamt.
          fmt_o    = FMT_SH;
          raw[4:0] = inst_i[24:20];
          if (XLEN == 64) raw[5] = inst_i[25];
        end else begin
          fmt_o = FMT_I;
          raw   = {{20{inst_i[31]}}, inst_i[31:20]};
        end
      end
      LOAD, JALR, SYSTEM: begin
        fmt_o = FMT_I;
        raw   = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          fmt_o = FMT_I;
          raw   = {{20{inst_i[31]}}, inst_i[31:20]};
        end else begin
          unsupported_o = 1'b1;
        end
      end
      STORE: begin
        fmt_o = FMT_S;
        raw   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      BRANCH: begin
        fmt_o = FMT_B;
        raw   = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        fmt_o = FMT_U;
        raw   = {inst_i[31:12], 12'b0};
      end
      JAL: begin
        fmt_o = FMT_J;
        raw   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      default: unsupported_o = 1'b1;
    endcase
  end

  if (XLEN > 32) begin : gWiden
    assign imm_o = {{(XLEN-32){raw[31]}}, raw};
  end else begin : gNative
    assign imm_o = raw[XLEN-1:0];
  end

endmodule

// File: rtl/riscv_imm_gen_pipe.sv
// Registered immediate generator: decoder feeding a main output register
// backed by one skid entry, so in_ready_o never depends on out_ready_i.
module riscv_imm_gen_pipe
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 flush_i,
  riscv_imm_gen_pipe_if.slave bus
);

  logic [XLEN-1:0] decImm;
  imm_fmt_t        decFmt;
  logic            decUns;

  logic            mainValid_q, mainValid_d;
  logic [XLEN-1:0] mainImm_q, mainImm_d;
  imm_fmt_t        mainFmt_q, mainFmt_d;
  logic            mainUns_q, mainUns_d;
  logic            skidValid_q, skidValid_d;
  logic [XLEN-1:0] skidImm_q, skidImm_d;
  imm_fmt_t        skidFmt_q, skidFmt_d;
  logic            skidUns_q, skidUns_d;

  logic accept;
  logic drain;

  imm_decode #(.XLEN(XLEN)) uDecode (
    .inst_i        (bus.Instruction_bus_i),
    .imm_o         (decImm),
    .fmt_o         (decFmt),
    .unsupported_o (decUns)
  );

  assign accept = bus.in_valid_i && !skidValid_q;
  assign drain  = mainValid_q && bus.out_ready_i;

  // The skid entry is always older than any new word, so it refills main first.
  always_comb begin
    mainValid_d = mainValid_q;
    mainImm_d   = mainImm_q;
    mainFmt_d   = mainFmt_q;
    mainUns_d   = mainUns_q;
    skidValid_d = skidValid_q;
    skidImm_d   = skidImm_q;
    skidFmt_d   = skidFmt_q;
    skidUns_d   = skidUns_q;
    if (flush_i) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (!mainValid_q || drain) begin
      if (skidValid_q) begin
        mainValid_d = 1'b1;
        mainImm_d   = skidImm_q;
        mainFmt_d   = skidFmt_q;
        mainUns_d   = skidUns_q;
        skidValid_d = 1'b0;
      end else if (accept) begin
        mainValid_d = 1'b1;
        mainImm_d   = decImm;
        mainFmt_d   = decFmt;
        mainUns_d   = decUns;
      end else begin
        mainValid_d = 1'b0;
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidImm_d   = decImm;
      skidFmt_d   = decFmt;
      skidUns_d   = decUns;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mainValid_q <= 1'b0;
      mainImm_q   <= '0;
      mainFmt_q   <= FMT_NONE;
      mainUns_q   <= 1'b0;
      skidValid_q <= 1'b0;
      skidImm_q   <= '0;
      skidFmt_q   <= FMT_NONE;
      skidUns_q   <= 1'b0;
    end else begin
      mainValid_q <= mainValid_d;
      mainImm_q   <= mainImm_d;
      mainFmt_q   <= mainFmt_d;
      mainUns_q   <= mainUns_d;
      skidValid_q <= skidValid_d;
      skidImm_q   <= skidImm_d;
      skidFmt_q   <= skidFmt_d;
      skidUns_q   <= skidUns_d;
    end
  end

  assign bus.in_ready_o    = !skidValid_q;
  assign bus.out_valid_o   = mainValid_q;
  assign bus.Immediate_o   = mainImm_q;
  assign bus.imm_fmt_o     = mainFmt_q;
  assign bus.unsupported_o = mainUns_q;

endmodule

// File: tb/tb_riscv_imm_gen_pipe.sv
// Scoreboard bench for the immediate generator: one XLEN=32 and one XLEN=64
// instance, expected results queued at acceptance and popped on each output.
module tb_riscv_imm_gen_pipe;
  import riscv_imm_pkg::*;

  typedef struct {
    logic [31:0] word;
    logic [63:0] imm;
    imm_fmt_t    fmt;
    logic        uns;
  } expT;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;

  expT q32[$];
  expT q64[$];
  expT e32;
  expT e64;

  riscv_imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  riscv_imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  riscv_imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .bus     (bus32)
  );

  riscv_imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .bus     (bus64)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Every handshake on the 32-bit output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && !flush && bus32.out_valid_o && bus32.out_ready_i) begin
      testsRun++;
      if (q32.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL out32_unexpected got imm=%h fmt=%0d expected no output", bus32.Immediate_o, bus32.imm_fmt_o);
      end else begin
        e32 = q32.pop_front();
        if (bus32.Immediate_o !== e32.imm[31:0] || bus32.imm_fmt_o !== e32.fmt || bus32.unsupported_o !== e32.uns) begin
          testsFailed++;
          $display("[TB] FAIL out32 word=%h got imm=%h fmt=%0d uns=%b expected imm=%h fmt=%0d uns=%b",
                   e32.word, bus32.Immediate_o, bus32.imm_fmt_o, bus32.unsupported_o, e32.imm[31:0], e32.fmt, e32.uns);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && !flush && bus64.out_valid_o && bus64.out_ready_i) begin
      testsRun++;
      if (q64.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL out64_unexpected got imm=%h fmt=%0d expected no output", bus64.Immediate_o, bus64.imm_fmt_o);
      end else begin
        e64 = q64.pop_front();
        if (bus64.Immediate_o !== e64.imm || bus64.imm_fmt_o !== e64.fmt || bus64.unsupported_o !== e64.uns) begin
          testsFailed++;
          $display("[TB] FAIL out64 word=%h got imm=%h fmt=%0d uns=%b expected imm=%h fmt=%0d uns=%b",
                   e64.word, bus64.Immediate_o, bus64.imm_fmt_o, bus64.unsupported_o, e64.imm, e64.fmt, e64.uns);
        end
      end
    end
  end

  // Drives one word and waits (bounded) for it to be accepted; leaves in_valid high.
  task automatic applyStimulus(input bit sel64, input logic [31:0] word, input logic [63:0] expImm,
                               input imm_fmt_t expFmt, input logic expUns);
    expT e;
    bit  rdy;
    bit  done;
    e.word = word;
    e.imm  = expImm;
    e.fmt  = expFmt;
    e.uns  = expUns;
    done   = 1'b0;
    if (sel64) begin
      bus64.in_valid_i        = 1'b1;
      bus64.Instruction_bus_i = word;
    end else begin
      bus32.in_valid_i        = 1'b1;
      bus32.Instruction_bus_i = word;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      rdy = sel64 ? bus64.in_ready_o : bus32.in_ready_o;
      @(posedge clk);
      #1;
      if (rdy && !flush) begin
        done = 1'b1;
        if (sel64) q64.push_back(e);
        else       q32.push_back(e);
      end
    end
    testsRun++;
    if (!done) begin
      testsFailed++;
      $display("[TB] FAIL accept_timeout word=%h got in_ready=0 expected 1 within 40 cycles", word);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #10;
    testsRun += 6;
    if (bus32.out_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_valid got %b expected 0", bus32.out_valid_o); end
    if (bus32.Immediate_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL rst_imm got %h expected 0", bus32.Immediate_o); end
    if (bus32.imm_fmt_o !== FMT_NONE) begin testsFailed++; $display("[TB] FAIL rst_fmt got %0d expected 0", bus32.imm_fmt_o); end
    if (bus32.unsupported_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_uns got %b expected 0", bus32.unsupported_o); end
    if (bus32.in_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_ready got %b expected 1", bus32.in_ready_o); end
    if (bus64.out_valid_o !== 1'b0 || bus64.in_ready_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst64 got valid=%b ready=%b expected valid=0 ready=1", bus64.out_valid_o, bus64.in_ready_o);
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_decode32();
    logic [31:0] words [12] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000FE3, 32'h001000EF,
                                32'h123450B7, 32'h01F09093, 32'h4030D093, 32'h00000033,
                                32'h0000101B, 32'h80002103, 32'hFFFFF097, 32'hFFDFF0EF};
    logic [31:0] imms  [12] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFE, 32'h00000800,
                                32'h12345000, 32'h0000001F, 32'h00000003, 32'h00000000,
                                32'h00000000, 32'hFFFFF800, 32'hFFFFF000, 32'hFFFFFFFC};
    imm_fmt_t    fmts  [12] = '{FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_SH, FMT_SH, FMT_NONE,
                                FMT_NONE, FMT_I, FMT_U, FMT_J};
    logic        unss  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b1, 1'b0, 1'b0, 1'b0};
    bus32.out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, words[i], {32'h0, imms[i]}, fmts[i], unss[i]);
      bus32.in_valid_i = 1'b0;
      testsRun++;
      if (bus32.out_valid_o !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL latency32 word=%h got out_valid=%b expected 1", words[i], bus32.out_valid_o);
      end
      waitCycles(1);
    end
  endtask

  task automatic test_decode64();
    bus64.out_ready_i = 1'b1;
    applyStimulus(1'b1, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
    applyStimulus(1'b1, 32'h0010009B, 64'h1, FMT_I, 1'b0);
    applyStimulus(1'b1, 32'h4230D093, 64'h23, FMT_SH, 1'b0);
    applyStimulus(1'b1, 32'h80000037, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0);
    applyStimulus(1'b1, 32'h00000033, 64'h0, FMT_NONE, 1'b1);
    bus64.in_valid_i = 1'b0;
    waitCycles(3);
    testsRun++;
    if (q64.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain64 got %0d pending expected 0", q64.size());
    end
  endtask

  task automatic test_back_to_back();
    int start;
    bus32.out_ready_i = 1'b1;
    start = cycleCount;
    applyStimulus(1'b0, 32'h00500093, 32'h5, FMT_I, 1'b0);
    applyStimulus(1'b0, 32'hFE112E23, 32'hFFFFFFFC, FMT_S, 1'b0);
    applyStimulus(1'b0, 32'h001000EF, 32'h800, FMT_J, 1'b0);
    applyStimulus(1'b0, 32'h00000073, 32'h0, FMT_I, 1'b0);
    bus32.in_valid_i = 1'b0;
    testsRun++;
    if (cycleCount - start != 4) begin
      testsFailed++;
      $display("[TB] FAIL throughput got %0d cycles expected 4", cycleCount - start);
    end
    waitCycles(3);
    testsRun++;
    if (q32.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain_b2b got %0d pending expected 0", q32.size());
    end
  endtask

  task automatic test_backpressure();
    int start;
    bus32.out_ready_i = 1'b0;
    applyStimulus(1'b0, 32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0);
    applyStimulus(1'b0, 32'hFE112E23, 32'hFFFFFFFC, FMT_S, 1'b0);
    testsRun++;
    if (bus32.in_ready_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp_ready_low got %b expected 0", bus32.in_ready_o);
    end
    bus32.Instruction_bus_i = 32'h123450B7;
    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      testsRun++;
      if (bus32.out_valid_o !== 1'b1 || bus32.Immediate_o !== 32'hFFFFFFFF ||
          bus32.imm_fmt_o !== FMT_I || bus32.in_ready_o !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold got valid=%b imm=%h fmt=%0d ready=%b expected valid=1 imm=ffffffff fmt=1 ready=0",
                 bus32.out_valid_o, bus32.Immediate_o, bus32.imm_fmt_o, bus32.in_ready_o);
      end
    end
    testsRun++;
    if (q32.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL bp_pending got %0d expected 2", q32.size());
    end
    bus32.out_ready_i = 1'b1;
    start = cycleCount;
    applyStimulus(1'b0, 32'h123450B7, 32'h12345000, FMT_U, 1'b0);
    bus32.in_valid_i = 1'b0;
    testsRun++;
    if (cycleCount - start != 2) begin
      testsFailed++;
      $display("[TB] FAIL bp_ready_rise got %0d cycles expected 2", cycleCount - start);
    end
    waitCycles(3);
    testsRun++;
    if (q32.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL bp_drain got %0d pending expected 0", q32.size());
    end
  endtask

  task automatic test_flush();
    bus32.out_ready_i = 1'b0;
    applyStimulus(1'b0, 32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0);
    applyStimulus(1'b0, 32'hFE000FE3, 32'hFFFFFFFE, FMT_B, 1'b0);
    bus32.Instruction_bus_i = 32'h001000EF;
    flush = 1'b1;
    waitCycles(1);
    flush            = 1'b0;
    bus32.in_valid_i = 1'b0;
    q32.delete();
    testsRun++;
    if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL flush_state got valid=%b ready=%b expected valid=0 ready=1", bus32.out_valid_o, bus32.in_ready_o);
    end
    bus32.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      testsRun++;
      if (bus32.out_valid_o !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL flush_dropped got valid=%b expected 0", bus32.out_valid_o);
      end
    end
    applyStimulus(1'b0, 32'h01F09093, 32'h1F, FMT_SH, 1'b0);
    bus32.in_valid_i = 1'b0;
    waitCycles(3);
    testsRun++;
    if (q32.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL flush_resume got %0d pending expected 0", q32.size());
    end
  endtask

  task automatic test_reset_midstream();
    bus32.out_ready_i = 1'b0;
    applyStimulus(1'b0, 32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0);
    applyStimulus(1'b0, 32'h00000033, 32'h0, FMT_NONE, 1'b1);
    bus32.in_valid_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    q32.delete();
    testsRun++;
    if (bus32.out_valid_o !== 1'b0 || bus32.Immediate_o !== 32'h0 || bus32.imm_fmt_o !== FMT_NONE ||
        bus32.unsupported_o !== 1'b0 || bus32.in_ready_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset got valid=%b imm=%h fmt=%0d uns=%b ready=%b expected 0 0 0 0 1",
               bus32.out_valid_o, bus32.Immediate_o, bus32.imm_fmt_o, bus32.unsupported_o, bus32.in_ready_o);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    bus32.out_ready_i = 1'b1;
    waitCycles(3);
    testsRun++;
    if (bus32.out_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_lost got valid=%b expected 0", bus32.out_valid_o);
    end
  endtask

  initial begin
    bus32.in_valid_i        = 1'b0;
    bus32.Instruction_bus_i = 32'h0;
    bus32.out_ready_i       = 1'b1;
    bus64.in_valid_i        = 1'b0;
    bus64.Instruction_bus_i = 32'h0;
    bus64.out_ready_i       = 1'b1;
    test_reset();
    test_decode32();
    test_decode64();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
